// File: rtl/smaesh_key_loader.sv
// Masked AES key loader: captures a d-share key on command and streams it to the
// core one 32-bit word per valid/ready handshake, share by share.
module smaesh_key_loader #(
    parameter int d = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [256*d-1:0]  cmd_key_shares,
    input  logic [1:0]        cmd_size_cfg,
    input  logic              cmd_inverse,
    output logic              out_key_valid,
    input  logic              out_key_ready,
    output logic [31:0]       out_key_data,
    output logic [1:0]        out_key_size_cfg,
    output logic              out_key_mode_inverse,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int SHARE_W = (d > 1) ? $clog2(d) : 1;
    localparam int WORDS   = 8 * d;
    localparam int IDX_W   = $clog2(WORDS);

    localparam logic [1:0] SIZE_128  = 2'b00;
    localparam logic [1:0] SIZE_192  = 2'b01;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                     state_q, state_d;
    logic [2:0]                 word_cnt_q, word_cnt_d;
    logic [SHARE_W-1:0]         share_cnt_q, share_cnt_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       load;

    // Latched key viewed as 8 words per share, share 0 in the low words.
    logic [WORDS-1:0][31:0]     key_q;
    logic [1:0]                 size_q;
    logic                       inv_q;

    logic [2:0]                 word_last_idx;
    logic                       word_last;
    logic                       share_last;
    logic [IDX_W-1:0]           word_idx;

    // Last word index within one share for the latched key size.
    always_comb begin
        case (size_q)
            SIZE_128: word_last_idx = 3'd3;
            SIZE_192: word_last_idx = 3'd5;
            default:  word_last_idx = 3'd7;
        endcase
    end

    assign word_last  = (word_cnt_q == word_last_idx);
    assign share_last = (share_cnt_q == SHARE_W'(d - 1));
    assign word_idx   = IDX_W'({share_cnt_q, word_cnt_q});

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        share_cnt_d = share_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_size_cfg == SIZE_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        load        = 1'b1;
                        word_cnt_d  = '0;
                        share_cnt_d = '0;
                        state_d     = SEND;
                    end
                end
            end
            SEND: begin
                if (out_key_ready) begin
                    if (word_last) begin
                        word_cnt_d = '0;
                        if (share_last) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            share_cnt_d = share_cnt_q + 1'b1;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            share_cnt_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            share_cnt_q <= share_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the key store is cleared on reset so no stale key material survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_q  <= '0;
            size_q <= SIZE_128;
            inv_q  <= 1'b0;
        end else if (load) begin
            key_q  <= cmd_key_shares;
            size_q <= cmd_size_cfg;
            inv_q  <= cmd_inverse;
        end
    end

    assign cmd_ready            = (state_q == IDLE);
    assign busy                 = (state_q == SEND);
    assign out_key_valid        = (state_q == SEND);
    assign out_key_data         = out_key_valid ? key_q[word_idx] : 32'h0;
    assign out_key_size_cfg     = size_q;
    assign out_key_mode_inverse = inv_q;
    assign done                 = done_q;
    assign err                  = err_q;

endmodule

// File: doc/smaesh_key_loader.md
SMAESH_KEY_LOADER -- requirements
Module: smaesh_key_loader

Interface
REQ-001 Parameter: d, default 2, number of shares (d >= 1).
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: cmd_valid  input  1  a key-load command is presented.
REQ-005 Port: cmd_ready  output  1  the block accepts a command this cycle.
REQ-006 Port: cmd_key_shares  input  256*d  share s occupies bits [256*s +: 256]; word k of share s is bits [256*s+32*k +: 32].
REQ-007 Port: cmd_size_cfg  input  2  key-size code: 2'b00=128, 2'b01=192, 2'b10=256, 2'b11 reserved.
REQ-008 Port: cmd_inverse  input  1  1 selects decryption key schedule.
REQ-009 Port: out_key_valid  output  1  out_key_data holds a valid word.
REQ-010 Port: out_key_ready  input  1  the core accepts the word (handshake = valid & ready).
REQ-011 Port: out_key_data  output  32  current key word.
REQ-012 Port: out_key_size_cfg  output  2  latched size code, stable for the whole transfer.
REQ-013 Port: out_key_mode_inverse  output  1  latched inverse flag, stable for the whole transfer.
REQ-014 Port: busy  output  1  a transfer is in progress.
REQ-015 Port: done  output  1  one-cycle pulse after the final word handshake.
REQ-016 Port: err  output  1  one-cycle pulse when a reserved size code is accepted.

Function
REQ-017 FSM states: IDLE, SEND; cmd_ready = 1 only in IDLE; busy = 1 only in SEND.
REQ-018 IDLE with cmd_valid=1 and a legal size code: latch cmd_key_shares, size code and inverse flag; clear word_cnt and share_cnt; go to SEND next cycle.
REQ-019 IDLE with cmd_valid=1 and size code 2'b11: the command is consumed; the block stays in IDLE; err=1 the following cycle; no word is emitted.
REQ-020 KWORDS = 4, 6 or 8 for codes 00, 01 or 10.
REQ-021 In SEND, out_key_valid=1 and out_key_data = word word_cnt of share share_cnt from the latched bus.
REQ-022 Emission order: share 0 words 0..KWORDS-1, then share 1 words 0..KWORDS-1, ... up to share d-1; KWORDS*d words in total.
REQ-023 Counters advance only on a handshake; word_cnt wraps to 0 at KWORDS-1 and share_cnt then increments.
REQ-024 With out_key_ready=0, out_key_data, out_key_size_cfg and out_key_mode_inverse stay constant and out_key_valid stays 1.
REQ-025 Handshake on word KWORDS-1 of share d-1: go to IDLE; done=1 in the next cycle, the same cycle cmd_ready returns to 1.
REQ-026 Latency: a command accepted at cycle N gives its first word valid at N+1; with out_key_ready held at 1, the last handshake is at N+KWORDS*d and the next command can be accepted at N+KWORDS*d+1.
REQ-027 cmd_key_shares, cmd_size_cfg and cmd_inverse changes during SEND have no effect on the outputs.
REQ-028 out_key_size_cfg and out_key_mode_inverse keep their last latched values in IDLE.
REQ-029 out_key_data reads 0 whenever out_key_valid=0.

Reset
REQ-030 rst=1 at a rising edge forces IDLE, clears both counters and the latched key to 0, and sets out_key_valid=0, done=0, err=0, busy=0, out_key_size_cfg=2'b00, out_key_mode_inverse=0.
REQ-031 rst during SEND aborts the transfer with no further words and no done pulse; cmd_ready=1 in the cycle after rst deasserts.
REQ-032 If rst and cmd_valid are both 1 in the same cycle, the command is not accepted.

Verification
REQ-033 d=2, code 00, share0 words 0x03020100/0x07060504/0x0B0A0908/0x0F0E0D0C, share1 all 0, ready held at 1 -> exactly 8 words in that order, then zeros; done pulse at N+9.
REQ-034 d=2, code 10, out_key_ready driven by a random bit each cycle -> 16 words in order, each held stable while stalled, none duplicated or skipped.
REQ-035 Code 11 with cmd_valid=1 -> err pulse one cycle later; out_key_valid stays 0; the next legal command is accepted normally.
REQ-036 d=3, code 01, cmd_inverse=1, cmd_key_shares changed every cycle during SEND -> 18 words from the bus latched at acceptance; out_key_mode_inverse=1 throughout.
REQ-037 rst asserted after the 3rd handshake of a 128-bit load -> out_key_valid=0 the next cycle; no done pulse; a new command then restarts from share 0 word 0.
REQ-038 Two back-to-back 128-bit commands with ready held at 1 -> second command accepted exactly one cycle after the first one's last handshake, for 16 words total.
